ram_dp_clr: RTL

RAM_DP_CLR -- requirements
Module: ram_dp_clr

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_clr_ctrl.sv | 66 ++++++
 rtl/ram_dp_clr.sv | 117 +++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM with clear engine.
// Holds the clear-FSM state type, the legal read-latency bounds and the
// read-latency range check used at elaboration.
package ram_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 2;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RdLatMin) && (lat <= RdLatMax);
  endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear engine: walks a counter over every memory word, issuing one zero write
// per cycle, then returns to idle.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; starts a clear at word 0
//   clr      in   clear request, sampled only while idle
//   busy     out  high while the clear runs (from the state register)
//   clr_we   out  clear write strobe
//   clr_addr out  address being zeroed this cycle
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // Last word reached: leave without wrapping the counter into a second pass.
        if (&cnt_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == StClear);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write port, one read port) with a full-memory
// clear engine and a 1- or 2-cycle read pipeline. Reads are read-first.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; clears read pipeline, starts a clear
//   clr      in   request a full-memory clear
//   busy     out  clear engine running; write and read ports ignored
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read request
//   rd_addr  in   read address
//   rd_data  out  read data, holds last value between reads
//   rd_valid out  one-cycle pulse marking rd_data valid
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_illegal
    $fatal(1, "ram_dp_clr: RD_LAT must be 1 or 2");
  end

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clr_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clr_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // No reset on the array so it can map onto block RAM; zeroing goes through
  // the clear engine only.
  logic [DATA_W-1:0] mem_q [Depth];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_acc;

  // Clear engine owns the write port while busy.
  always_comb begin
    mem_we    = clr_we | (wr_en & ~busy);
    mem_waddr = clr_we ? clr_addr : wr_addr;
    mem_wdata = clr_we ? '0 : wr_data;
    rd_acc    = rd_en & ~busy;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // First read stage; sampling before the write lands gives read-first order.
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_data_q <= mem_q[rd_addr];
      end
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign rd_data  = s1_data_q;
    assign rd_valid = s1_valid_q;
  end else begin : g_lat2
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_data  = s2_data_q;
    assign rd_valid = s2_valid_q;
  end

endmodule
